// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Reader side of the instruction memory. Owns the program counter, captures
//   each 16-bit instruction into an instruction register (IR), resolves the
//   control-flow opcodes (jump, conditional jump, halt) itself and hands every
//   other opcode to the datapath over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        begins execution at PC=0 from IDLE or HALTED
//   address      PC presented to the instruction memory (0 while IDLE)
//   instruction  combinational memory read data for address
//   regReadAddr  register-file read select (IR[7:4])
//   condValue    register-file read data for regReadAddr
//   opcode, destReg, src1Reg, src2Reg, immediate   decoded IR fields
//   execValid    data instruction presented to the datapath
//   execReady    datapath has completed the presented instruction
//   running      high in FETCH or EXEC
//   halted       high in HALTED
//   fault        sticky out-of-range PC (or watchdog expiry)
//
// Build option
//   FETCH_WATCHDOG_EN  when defined, a retirement budget of WATCHDOG_LIMIT
//                      instructions is enforced; once spent, the next EXEC
//                      exit halts with fault=1.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, waiting for start, address forced to 0
// FETCH  | one cycle: IR <= instruction at PC
// EXEC   | resolve control op, or hold execValid until execReady
// HALTED | halt opcode, PC fault or watchdog; wait for start

module fetch_sequencer #(
  parameter int PROG_DEPTH     = 128,
  parameter int WATCHDOG_LIMIT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  address,
  input  logic [15:0] instruction,
  output logic [3:0]  regReadAddr,
  input  logic [7:0]  condValue,
  output logic [3:0]  opcode,
  output logic [3:0]  destReg,
  output logic [3:0]  src1Reg,
  output logic [3:0]  src2Reg,
  output logic [7:0]  immediate,
  output logic        execValid,
  input  logic        execReady,
  output logic        running,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_CJUMP = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  // 9 bits so that a depth of 256 (whole address space) is still representable.
  localparam logic [8:0] DEPTH    = 9'(PROG_DEPTH);

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  pcNext;
  logic        targetFault;
  logic        irIsControl;
  logic        execExit;
  logic        wdExpired;

  // Jump with destReg!=0 is a register copy and goes to the datapath.
  function automatic logic isControl(input logic [15:0] insn);
    return (insn[15:12] == OP_HALT) || (insn[15:12] == OP_CJUMP) ||
           ((insn[15:12] == OP_JUMP) && (insn[11:8] == 4'd0));
  endfunction

  assign opcode      = ir[15:12];
  assign destReg     = ir[11:8];
  assign src1Reg     = ir[7:4];
  assign src2Reg     = ir[3:0];
  assign immediate   = ir[7:0];
  assign regReadAddr = ir[7:4];
  // PC is only ever 0 while IDLE, so it can drive the memory directly.
  assign address     = pc;

  assign irIsControl = isControl(ir);
  // execReady only matters while a data instruction is being presented.
  assign execExit    = (state == EXEC) && (irIsControl || execReady);

  // 8-bit adds wrap modulo 256; adding the raw byte equals adding its sign extension.
  always_comb begin
    pcNext = pc + 8'd1;
    if ((opcode == OP_JUMP) && (destReg == 4'd0)) begin
      pcNext = pc + 8'd1 + ir[7:0];
    end else if ((opcode == OP_CJUMP) && (condValue != 8'd0)) begin
      pcNext = pc + 8'd1 + {{4{ir[3]}}, ir[3:0]};
    end
  end

  assign targetFault = ({1'b0, pcNext} >= DEPTH);

`ifdef FETCH_WATCHDOG_EN
  // Remaining retirement budget; counts down from WATCHDOG_LIMIT.
  logic [15:0] wdBudget;
  assign wdExpired = (wdBudget == 16'd0);
`else
  assign wdExpired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= 8'd0;
      ir        <= 16'd0;
      execValid <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
`ifdef FETCH_WATCHDOG_EN
      wdBudget  <= 16'(WATCHDOG_LIMIT);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            pc      <= 8'd0;
            running <= 1'b1;
`ifdef FETCH_WATCHDOG_EN
            wdBudget <= 16'(WATCHDOG_LIMIT);
`endif
          end
        end

        FETCH: begin
          ir        <= instruction;
          // Decode the incoming word so execValid is registered on EXEC entry.
          execValid <= !isControl(instruction);
          state     <= EXEC;
        end

        EXEC: begin
          if (execExit) begin
            execValid <= 1'b0;
            if (opcode == OP_HALT) begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
            end else if (wdExpired || targetFault) begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
              fault   <= 1'b1;
            end else begin
              pc    <= pcNext;
              state <= FETCH;
`ifdef FETCH_WATCHDOG_EN
              wdBudget <= wdBudget - 16'd1;
`endif
            end
          end
        end

        HALTED: begin
          if (start) begin
            state   <= FETCH;
            pc      <= 8'd0;
            fault   <= 1'b0;
            halted  <= 1'b0;
            running <= 1'b1;
`ifdef FETCH_WATCHDOG_EN
            wdBudget <= 16'(WATCHDOG_LIMIT);
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  address;
  logic [15:0] instruction;
  logic [3:0]  regReadAddr;
  logic [7:0]  condValue;
  logic [3:0]  opcode;
  logic [3:0]  destReg;
  logic [3:0]  src1Reg;
  logic [3:0]  src2Reg;
  logic [7:0]  immediate;
  logic        execValid;
  logic        execReady;
  logic        running;
  logic        halted;
  logic        fault;

  logic [15:0] mem [0:255];

  typedef struct {
    int addr;
    int op;
    int dst;
  } exec_t;

  typedef struct {
    int addr;
    int flt;
  } halt_t;

  exec_t execQ[$];
  halt_t haltQ[$];

  int nChecks = 0;
  int nPass   = 0;
  logic haltedPrev = 1'b0;

  fetch_sequencer #(
    .PROG_DEPTH(128),
    .WATCHDOG_LIMIT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .address(address),
    .instruction(instruction),
    .regReadAddr(regReadAddr),
    .condValue(condValue),
    .opcode(opcode),
    .destReg(destReg),
    .src1Reg(src1Reg),
    .src2Reg(src2Reg),
    .immediate(immediate),
    .execValid(execValid),
    .execReady(execReady),
    .running(running),
    .halted(halted),
    .fault(fault)
  );

  assign instruction = mem[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops a scoreboard entry on every completed handshake and on every halt.
  always @(negedge clk) begin
    exec_t e;
    halt_t h;
    #2;
    if (!reset) begin
      if (execValid && execReady) begin
        if (execQ.size() == 0) begin
          check("unexpected exec", int'(address), -1);
        end else begin
          e = execQ.pop_front();
          check("exec address", int'(address), e.addr);
          check("exec opcode", int'(opcode), e.op);
          check("exec destReg", int'(destReg), e.dst);
        end
      end
      if (halted && !haltedPrev) begin
        if (haltQ.size() == 0) begin
          check("unexpected halt", int'(address), -1);
        end else begin
          h = haltQ.pop_front();
          check("halt address", int'(address), h.addr);
          check("halt fault", int'(fault), h.flt);
        end
      end
    end
    haltedPrev = halted;
  end

  task automatic pushExec(input int a, input int o, input int d);
    exec_t e;
    e.addr = a; e.op = o; e.dst = d;
    execQ.push_back(e);
  endtask

  task automatic pushHalt(input int a, input int f);
    halt_t h;
    h.addr = a; h.flt = f;
    haltQ.push_back(h);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge after the edge that samples start (cycle 1).
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitHalt(input int budget);
    int cyc;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!halted) check("halt timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int pulses;
    reset     = 1'b1;
    start     = 1'b0;
    execReady = 1'b0;
    condValue = 8'd0;
    clearMem();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset execValid", int'(execValid), 0);
    check("reset running", int'(running), 0);
    check("reset halted", int'(halted), 0);
    check("reset fault", int'(fault), 0);
    check("reset address", int'(address), 0);
    check("reset opcode", int'(opcode), 0);
    check("reset immediate", int'(immediate), 0);

    // Straight-line program, ready tied high
    mem[0] = 16'h0102; mem[1] = 16'h0203; mem[2] = 16'h4F21; mem[3] = 16'hE000;
    execReady = 1'b1;
    pushExec(0, 0, 1); pushExec(1, 0, 2); pushExec(2, 4, 15);
    pushHalt(3, 0);
    pulseStart();
    cyc = 1; pulses = 0;
    while (!halted && cyc < 30) begin
      if (execValid) pulses++;
      if (cyc == 1 || cyc == 3 || cyc == 5 || cyc == 7)
        check("fetch address", int'(address), (cyc - 1) / 2);
      @(negedge clk);
      cyc++;
    end
    check("halt cycle", cyc, 9);
    check("execValid pulses", pulses, 3);

    // Unconditional jumps, backward and forward
    doReset(); clearMem();
    mem[0] = 16'h2004; mem[5] = 16'h20FD; mem[3] = 16'h3104;
    mem[4] = 16'h2002; mem[7] = 16'h2001; mem[9] = 16'h5200;
    pushExec(3, 3, 1); pushExec(9, 5, 2); pushHalt(10, 0);
    pulseStart();
    waitHalt(60);

    // Conditional jump taken and not taken
    for (int t = 0; t < 2; t++) begin
      doReset(); clearMem();
      mem[0] = 16'h2005; mem[6] = 16'hC051; mem[7] = 16'h6700; mem[8] = 16'h7800;
      condValue = (t == 0) ? 8'd1 : 8'd0;
      if (t == 1) pushExec(7, 6, 7);
      pushExec(8, 7, 8);
      pushHalt(9, 0);
      pulseStart();
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("cjump regReadAddr", int'(regReadAddr), 5);
      check("cjump address", int'(address), 6);
      waitHalt(60);
    end

    // Handshake stall
    doReset(); clearMem();
    execReady = 1'b0;
    mem[0] = 16'h9A12;
    pushExec(0, 9, 10); pushHalt(1, 0);
    pulseStart();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stall execValid", int'(execValid), 1);
      check("stall opcode", int'(opcode), 9);
      check("stall destReg", int'(destReg), 10);
      check("stall address", int'(address), 0);
      @(negedge clk);
    end
    execReady = 1'b1;
    @(negedge clk);
    check("post-ready execValid", int'(execValid), 0);
    check("post-ready address", int'(address), 1);
    waitHalt(20);

    // Out-of-range jump target (0+1+0xC7 = 200), then restart
    doReset(); clearMem();
    mem[0] = 16'h20C7;
    pushHalt(0, 1);
    pulseStart();
    waitHalt(20);
    check("fault sticky", int'(fault), 1);
    pushHalt(0, 1);
    pulseStart();
    check("restart fault cleared", int'(fault), 0);
    check("restart address", int'(address), 0);
    check("restart running", int'(running), 1);
    waitHalt(20);

    // Reset in the middle of a stalled handshake
    doReset(); clearMem();
    execReady = 1'b0;
    mem[0] = 16'h1100;
    pulseStart();
    @(negedge clk);
    check("pre-reset execValid", int'(execValid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-exec reset execValid", int'(execValid), 0);
    check("mid-exec reset address", int'(address), 0);
    check("mid-exec reset running", int'(running), 0);

    // Self-loop 0x20FF
    @(negedge clk);
    clearMem();
    mem[0] = 16'h20FF;
    execReady = 1'b1;
`ifdef FETCH_WATCHDOG_EN
    pushHalt(0, 1);
    pulseStart();
    cyc = 1;
    while (!halted && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("watchdog halt cycle", cyc, 23);
    check("watchdog fault", int'(fault), 1);
`else
    pulseStart();
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("self-loop running", int'(running), 1);
    check("self-loop fault", int'(fault), 0);
    check("self-loop halted", int'(halted), 0);
    check("self-loop address", int'(address), 0);
`endif
    doReset();
    @(negedge clk);
    @(negedge clk);

    check("exec queue drained", execQ.size(), 0);
    check("halt queue drained", haltQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
